// File: rtl/fc_seq_ctrl_if.sv
// Element stream in / scored result out bundle for fc_seq_ctrl.
// The slave modport is the sequencer's view; master is the upstream/downstream side.
interface fc_seq_ctrl_if #(
    parameter int CLASS_NUM = 2,
    parameter int D_WL      = 24,
    parameter int CIW       = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1
);
    logic                      s_valid;
    logic                      s_ready;
    logic [D_WL-1:0]           s_data;
    logic                      s_last;
    logic                      m_valid;
    logic                      m_ready;
    logic [CLASS_NUM*D_WL-1:0] m_scores;
    logic [CIW-1:0]            m_class;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_scores, m_class
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_scores, m_class
    );
endinterface

// File: rtl/fc_seq_ctrl.sv
// Sequencer for the LSTM fully-connected output layer: feeds one hidden vector, captures scores,
// optionally finds the argmax class. Define FC_ARGMAX_EN to build the sequential argmax stage.
module fc_seq_ctrl #(
    parameter int CLASS_NUM  = 2,
    parameter int INPUT_SIZE = 30,
    parameter int D_WL       = 24,
    parameter int CIW        = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fc_seq_ctrl_if.slave              sif,
    output logic                      fc_r_en,
    output logic                      fc_in_valid,
    output logic [D_WL-1:0]           fc_x,
    input  logic                      fc_o_valid,
    input  logic [CLASS_NUM*D_WL-1:0] fc_f_o,
    output logic                      len_err,
    output logic                      busy
);
    localparam int            CW       = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(INPUT_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        WAIT,
`ifdef FC_ARGMAX_EN
        ARG,
`endif
        OUT
    } state_t;

    function automatic logic signed [D_WL-1:0] score_at(input logic [CLASS_NUM*D_WL-1:0] vec,
                                                        input int idx);
        return $signed(vec[idx*D_WL +: D_WL]);
    endfunction

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic                      s_ready_q;
    logic                      m_valid_q;
    logic [CLASS_NUM*D_WL-1:0] m_scores_q;
    logic                      accept;
    logic                      at_last;

    assign accept       = sif.s_valid && s_ready_q;
    assign at_last      = (cnt == CNT_LAST);
    assign fc_r_en      = accept;
    assign busy         = (state != IDLE);
    assign sif.s_ready  = s_ready_q;
    assign sif.m_valid  = m_valid_q;
    assign sif.m_scores = m_scores_q;

`ifdef FC_ARGMAX_EN
    logic [CIW-1:0]         arg_idx;
    logic [CIW-1:0]         best_idx;
    logic [CIW-1:0]         m_class_q;
    logic signed [D_WL-1:0] best_val;
    logic signed [D_WL-1:0] cand;

    assign cand        = score_at(m_scores_q, int'(arg_idx));
    assign sif.m_class = m_class_q;
`else
    assign sif.m_class = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            s_ready_q   <= 1'b0;
            fc_in_valid <= 1'b0;
            fc_x        <= '0;
            len_err     <= 1'b0;
            m_valid_q   <= 1'b0;
            m_scores_q  <= '0;
`ifdef FC_ARGMAX_EN
            arg_idx     <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            m_class_q   <= '0;
`endif
        end else begin
            // Feed stage: registered element lines up with the weight read issued this cycle
            fc_in_valid <= accept;
            len_err     <= accept && (sif.s_last != at_last);
            if (accept) begin
                fc_x <= sif.s_data;
            end

            case (state)
                IDLE, FEED: begin
                    s_ready_q <= 1'b1;
                    // Length is decided by count alone so the weight buffer stays in step
                    if (accept) begin
                        if (at_last) begin
                            state     <= WAIT;
                            cnt       <= '0;
                            s_ready_q <= 1'b0;
                        end else begin
                            state <= FEED;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end

                WAIT: begin
                    if (fc_o_valid) begin
                        m_scores_q <= fc_f_o;
`ifdef FC_ARGMAX_EN
                        if (CLASS_NUM > 1) begin
                            state    <= ARG;
                            arg_idx  <= CIW'(1);
                            best_idx <= '0;
                            best_val <= score_at(fc_f_o, 0);
                        end else begin
                            state     <= OUT;
                            m_valid_q <= 1'b1;
                            m_class_q <= '0;
                        end
`else
                        state     <= OUT;
                        m_valid_q <= 1'b1;
`endif
                    end
                end

`ifdef FC_ARGMAX_EN
                // Argmax stage: strict greater-than keeps the lower index on ties
                ARG: begin
                    if (cand > best_val) begin
                        best_val <= cand;
                        best_idx <= arg_idx;
                    end
                    if (arg_idx == CIW'(CLASS_NUM - 1)) begin
                        m_class_q <= (cand > best_val) ? arg_idx : best_idx;
                        m_valid_q <= 1'b1;
                        state     <= OUT;
                    end else begin
                        arg_idx <= arg_idx + 1'b1;
                    end
                end
`endif

                OUT: begin
                    if (sif.m_ready) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed scoreboard bench for fc_seq_ctrl (4 classes, 30-element vectors).
// Expectations adapt to whether FC_ARGMAX_EN is defined.
module tb_fc_seq_ctrl;
    localparam int CN  = 4;
    localparam int IS  = 30;
    localparam int DW  = 24;
    localparam int CIW = 2;
`ifdef FC_ARGMAX_EN
    localparam int LAT = CN - 1;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fc_r_en;
    logic             fc_in_valid;
    logic [DW-1:0]    fc_x;
    logic             fc_o_valid;
    logic [CN*DW-1:0] fc_f_o;
    logic             len_err;
    logic             busy;

    always #5 clk = ~clk;

    fc_seq_ctrl_if #(.CLASS_NUM(CN), .D_WL(DW), .CIW(CIW)) sif ();

    fc_seq_ctrl #(.CLASS_NUM(CN), .INPUT_SIZE(IS), .D_WL(DW), .CIW(CIW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sif        (sif),
        .fc_r_en    (fc_r_en),
        .fc_in_valid(fc_in_valid),
        .fc_x       (fc_x),
        .fc_o_valid (fc_o_valid),
        .fc_f_o     (fc_f_o),
        .len_err    (len_err),
        .busy       (busy)
    );

    typedef struct {
        logic [CN*DW-1:0] sc;
        logic [CIW-1:0]   cls;
    } res_t;

    int               total = 0;
    int               bad = 0;
    int               rd_cnt = 0;
    int               le_cnt = 0;
    int               sc[CN];
    logic [CN*DW-1:0] last_pk;
    logic [DW-1:0]    xq[$];
    res_t             rq[$];
    logic [DW-1:0]    x_exp;
    res_t             r_exp;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_scores(input int a, input int b, input int c, input int d);
        sc[0] = a;
        sc[1] = b;
        sc[2] = c;
        sc[3] = d;
    endtask

    function automatic int exp_class();
`ifdef FC_ARGMAX_EN
        int b = 0;
        for (int j = 1; j < CN; j++)
            if (sc[j] > sc[b]) b = j;
        return b;
`else
        return 0;
`endif
    endfunction

    // Present one element and wait (bounded) until it is accepted.
    task automatic push_elem(input bit last);
        int n = 0;
        bit ok = 1'b0;
        sif.s_valid = 1'b1;
        sif.s_data  = DW'($urandom);
        sif.s_last  = last;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = sif.s_ready;
            tick();
            n++;
        end
        if (!ok) chk("accept_timeout", ok, 1);
    endtask

    task automatic send_vec(input int early_last, input bit end_last, input int bp);
        logic [CN*DW-1:0] pk;
        res_t             r;
        int               n;
        int               cls;
        rd_cnt = 0;
        le_cnt = 0;
        for (int i = 0; i < IS; i++) push_elem(((i + 1) == early_last) || (end_last && i == IS - 1));
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        chk("reads_per_vec", rd_cnt, IS);
        chk("s_ready_in_wait", sif.s_ready, 0);
        chk("busy_in_wait", busy, 1);
        repeat (3) tick();
        for (int j = 0; j < CN; j++) pk[j*DW +: DW] = sc[j][DW-1:0];
        cls   = exp_class();
        r.sc  = pk;
        r.cls = CIW'(cls);
        rq.push_back(r);
        last_pk = pk;
        sif.m_ready = (bp == 0);
        fc_f_o      = pk;
        fc_o_valid  = 1'b1;
        tick();
        fc_o_valid = 1'b0;
        fc_f_o     = ~pk;
        chk("m_scores_at_r1", sif.m_scores, pk);
        n = 0;
        while (!sif.m_valid && n < 20) begin
            tick();
            n++;
        end
        chk("m_valid_latency", n, LAT);
        chk("m_class", sif.m_class, cls);
        chk("len_err_pulses", le_cnt, int'(early_last != 0) + int'(!end_last));
        if (bp > 0) begin
            sif.s_valid = 1'b1;
            sif.s_data  = DW'($urandom);
            for (int k = 0; k < bp; k++) begin
                tick();
                chk("bp_m_valid", sif.m_valid, 1);
                chk("bp_m_scores", sif.m_scores, pk);
                chk("bp_m_class", sif.m_class, cls);
                chk("bp_s_ready", sif.s_ready, 0);
                chk("bp_fc_r_en", fc_r_en, 0);
            end
        end
        sif.m_ready = 1'b1;
        tick();
        chk("s_ready_after_hs", sif.s_ready, 1);
        chk("m_valid_after_hs", sif.m_valid, 0);
        chk("busy_after_hs", busy, 0);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            xq.delete();
        end else begin
            if (fc_in_valid || xq.size() != 0) begin
                if (xq.size() == 0) begin
                    chk("fc_in_valid_spurious", fc_in_valid, 0);
                end else begin
                    x_exp = xq.pop_front();
                    chk("fc_in_valid", fc_in_valid, 1);
                    chk("fc_x", fc_x, x_exp);
                end
            end
            if (fc_r_en || (sif.s_valid && sif.s_ready))
                chk("fc_r_en_vs_accept", fc_r_en, sif.s_valid && sif.s_ready);
            if (sif.s_valid && sif.s_ready) xq.push_back(sif.s_data);
            if (fc_r_en) rd_cnt++;
            if (len_err) le_cnt++;
            if (sif.m_valid && sif.m_ready) begin
                if (rq.size() == 0) begin
                    chk("m_valid_unexpected", sif.m_valid, 0);
                end else begin
                    r_exp = rq.pop_front();
                    chk("res_scores", sif.m_scores, r_exp.sc);
                    chk("res_class", sif.m_class, r_exp.cls);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        sif.m_ready = 1'b1;
        fc_o_valid  = 1'b0;
        fc_f_o      = '0;

        // Reset: every output at its reset value
        repeat (3) begin
            @(negedge clk);
            chk("rst_s_ready", sif.s_ready, 0);
            chk("rst_fc_r_en", fc_r_en, 0);
            chk("rst_fc_in_valid", fc_in_valid, 0);
            chk("rst_fc_x", fc_x, 0);
            chk("rst_m_valid", sif.m_valid, 0);
            chk("rst_m_scores", sif.m_scores, 0);
            chk("rst_m_class", sif.m_class, 0);
            chk("rst_len_err", len_err, 0);
            chk("rst_busy", busy, 0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        chk("s_ready_after_rst", sif.s_ready, 1);
        chk("busy_after_rst", busy, 0);

        // Nominal vector: class1=0x001980, class0=0xFFE680
        set_scores(-6528, 6528, -1000, 100);
        send_vec(0, 1'b1, 0);

        // Early s_last on element 10 (plus proper one on 30), tie between 1 and 2
        set_scores(-5, 7, 7, -1);
        send_vec(10, 1'b1, 0);

        // Missing s_last, all negative, 20 cycles of backpressure
        set_scores(-3, -1, -8, -2);
        send_vec(0, 1'b0, 20);

        // Immediately following vector, tie at the top two classes
        set_scores(10, -20, 30, 30);
        send_vec(0, 1'b1, 0);

        // Reset in the middle of FEED after 12 elements
        rd_cnt = 0;
        for (int i = 0; i < 12; i++) push_elem(1'b0);
        sif.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_s_ready", sif.s_ready, 0);
        chk("midrst_fc_in_valid", fc_in_valid, 0);
        chk("midrst_reads", rd_cnt, 12);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        set_scores(-8388608, 8388607, 0, -1);
        send_vec(0, 1'b1, 0);

        // All equal: lowest index wins
        set_scores(5, 5, 5, 5);
        send_vec(0, 1'b1, 0);

        // fc_o_valid outside WAIT is ignored
        fc_f_o     = ~last_pk;
        fc_o_valid = 1'b1;
        tick();
        fc_o_valid = 1'b0;
        tick();
        chk("ignored_fc_o_m_valid", sif.m_valid, 0);
        chk("ignored_fc_o_busy", busy, 0);
        chk("ignored_fc_o_scores", sif.m_scores, last_pk);

        repeat (3) tick();
        chk("result_queue_drained", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fc_seq_ctrl.md
# fc_seq_ctrl

Sequencer for the fully-connected output layer of the LSTM network. It accepts one hidden-state vector per inference as a valid/ready element stream and issues exactly INPUT_SIZE weight-buffer reads and FC input beats per vector. It then captures the CLASS_NUM scores and returns them downstream together with the winning class index. It sits between the LSTM layer output and the fully-connected layer, and owns the weight buffer read enable.

## Interface
- CLASS_NUM, 2, number of output classes / FC PEs
- INPUT_SIZE, 30, elements per hidden vector
- D_WL, 24, data word length (two's complement, fixed point)
- CIW, $clog2(CLASS_NUM) (min 1), width of class index
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  upstream element valid
- s_ready  out  1  element accepted when s_valid && s_ready
- s_data  in  D_WL  hidden-state element
- s_last  in  1  upstream marks final element of vector
- fc_r_en  out  1  weight buffer read-enable (advances buffer address; weight valid next cycle)
- fc_in_valid  out  1  FC input beat valid
- fc_x  out  D_WL  FC input element
- fc_o_valid  in  1  FC result valid (class 0 PE)
- fc_f_o  in  CLASS_NUM*D_WL  FC scores, class j at [j*D_WL +: D_WL]
- m_valid  out  1  result valid, held until m_ready
- m_ready  in  1  downstream accept
- m_scores  out  CLASS_NUM*D_WL  captured scores, same packing as fc_f_o
- m_class  out  CIW  argmax class index
- len_err  out  1  one-cycle pulse on vector-length mismatch
- busy  out  1  high in any state but IDLE

## Operation
- FSM states: IDLE, FEED, WAIT, ARG, OUT. Reset state IDLE.
- IDLE/FEED: s_ready=1. Each accepted element: fc_r_en=1 same cycle, element registered to fc_x, fc_in_valid=1 next cycle. Element counter cnt increments 0..INPUT_SIZE-1. The first accept moves IDLE→FEED; the accept with cnt==INPUT_SIZE-1 moves to WAIT and clears cnt.
- Length is by count, not by s_last. len_err pulses (cycle after the accept) if s_last=1 with cnt!=INPUT_SIZE-1, or s_last=0 with cnt==INPUT_SIZE-1. The vector is still processed as INPUT_SIZE elements, so the weight buffer never desynchronizes.
- INPUT_SIZE==1: first accept goes IDLE→WAIT directly.
- WAIT: s_ready=0. On fc_o_valid, latch fc_f_o into m_scores, then go to ARG. Without FC_ARGMAX_EN, go to OUT instead. fc_o_valid in any other state is ignored.
- ARG: sequential argmax, one compare per cycle over classes 1..CLASS_NUM-1. Signed compare. A strictly greater score replaces the best, so a tie keeps the lower index. After CLASS_NUM-1 cycles go to OUT. CLASS_NUM==1 spends 0 cycles in ARG.
- OUT: m_valid=1 and m_scores/m_class stable until m_valid && m_ready, then IDLE. s_ready stays 0 in OUT.
- Reset mid-operation: all state cleared immediately and the partial vector is abandoned. FC PEs and the weight buffer share rst_n, so no drain is needed.

## Timing
- Reset values: s_ready 0 (rises first cycle after rst_n release), fc_r_en 0, fc_in_valid 0, fc_x 0, m_valid 0, m_scores 0, m_class 0, len_err 0, busy 0.
- Throughput in FEED: 1 element/cycle. Back-to-back accepts give a contiguous fc_in_valid burst.
- Last accept at cycle T: fc_in_valid at T+1; WAIT from T+1.
- fc_o_valid seen at cycle R: m_scores valid at R+1. m_valid rises at R+1+(CLASS_NUM-1) with argmax, R+1 without.
- OUT→IDLE on handshake cycle H; s_ready=1 at H+1. Minimum gap between vectors is the FC latency plus 2+(CLASS_NUM-1) cycles.
- fc_r_en is never asserted outside IDLE/FEED. Exactly INPUT_SIZE fc_r_en pulses per vector.

## Configuration
- FC_ARGMAX_EN defined: ARG state, comparator and m_class register are present.
- Undefined: ARG state removed, m_class tied 0, m_valid one cycle earlier as in Timing. Scores are still output.

## Test plan
- Reset: rst_n low 3 cycles, then release. Every output holds its reset value during reset; s_ready=1 on the first cycle after release; busy=0.
- Nominal vector: INPUT_SIZE=30 contiguous elements with s_last on the 30th, FC model returns scores {class1=0x001980, class0=0xFFE680} → 30 fc_r_en pulses, fc_in_valid T+1 aligned with data, m_scores captured, m_class=1, len_err=0.
- Length error: s_last on element 10 of 30 → len_err single pulse; 30 reads still issued; result delivered normally.
- Backpressure: hold m_ready=0 for 20 cycles with s_valid=1 → m_valid/m_scores stable, s_ready=0, no fc_r_en; m_ready=1 → IDLE, next vector accepted the cycle after.
- Tie/sign: CLASS_NUM=4, scores {-5,7,7,-1} → m_class=1. All negative {-3,-1,-8,-2} → m_class=1. Without FC_ARGMAX_EN → m_class=0, m_valid at R+1.
- Reset mid-FEED after 12 elements → immediate IDLE. The next full vector produces exactly 30 reads and a correct result.
